very_half_sam_core: RTL and testbench

The block is an 8-bit single-accumulator processor core ("Very Half SAM"). It fetches and executes one-byte instructions from an external 256-byte memory over a shared address/data bus that is strobed by ALE, En and Rw. It has a console port that can pause execution and display any architectural register. It sits between the board console and an external synchronous memory model.

---
 rtl/very_half_sam_core.sv | 202 ++++++++++++++++++++
 tb/tb_very_half_sam_core.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/very_half_sam_core.sv
// very_half_sam_core: 8-bit single-accumulator processor core (Very Half SAM).
// Fetches/executes one-byte instructions over an ALE/En/Rw strobed memory bus; console can pause and display registers.
module very_half_sam_core (
  input  logic       clk,
  input  logic       rst,
  output logic       ALE,
  output logic [7:0] Address_Bus,
  inout  wire  [7:0] Data_Bus,
  output logic       En,
  output logic       Rw,
  input  logic       pause,
  input  logic [1:0] regSelect,
  output logic [7:0] dispReg
);

  typedef enum logic [3:0] {
    S_FETCH_A, S_FETCH_B, S_FETCH_C,
    S_EXEC,
    S_RD1_B, S_RD1_C,
    S_RD2_A, S_RD2_B, S_RD2_C,
    S_WR_A, S_WR_B,
    S_PAUSED, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_MISC   = 4'h0, OP_BR     = 4'h1, OP_BRZ    = 4'h2, OP_BRP    = 4'h3,
    OP_BRN    = 4'h4, OP_BRIND  = 4'h5, OP_CLOAD  = 4'h6, OP_DLOAD  = 4'h7,
    OP_ILOAD  = 4'h8, OP_DSTORE = 4'h9, OP_ISTORE = 4'hA, OP_ADD    = 4'hB,
    OP_AND    = 4'hC
  } opcode_t;

  state_t  r_state;
  state_t  w_next;
  state_t  w_after;
  logic [7:0] r_pc;
  logic [7:0] r_ireg;
  logic [7:0] r_acc;
  logic [7:0] r_iar;

  opcode_t    w_op;
  logic [3:0] w_x;
  logic [7:0] w_sext;
  logic [7:0] w_daddr;
  logic       w_taken;
  logic       w_rd_op;
  logic       w_halt;
  logic       w_drive;

  assign w_op    = opcode_t'(r_ireg[7:4]);
  assign w_x     = r_ireg[3:0];
  assign w_sext  = {{4{w_x[3]}}, w_x};
  assign w_daddr = {4'h0, w_x};
  assign w_halt  = ((w_op == OP_MISC) && (w_x == 4'h0)) || (r_ireg[7:4] >= 4'hD);
  assign w_after = pause ? S_PAUSED : S_FETCH_A;

  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      OP_BR:   w_taken = 1'b1;
      OP_BRZ:  w_taken = (r_acc == '0);
      OP_BRP:  w_taken = !r_acc[7] && (r_acc != '0);
      OP_BRN:  w_taken = r_acc[7];
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_rd_op = 1'b0;
    case (w_op)
      OP_BRIND, OP_DLOAD, OP_ILOAD, OP_ISTORE, OP_ADD, OP_AND: w_rd_op = 1'b1;
      default: w_rd_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH_A;
    else      r_state <= w_next;
  end

  // The first memory phase of every instruction (read A or dstore write A) overlaps the EXEC cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH_A: w_next = S_FETCH_B;
      S_FETCH_B: w_next = S_FETCH_C;
      S_FETCH_C: w_next = S_EXEC;
      S_EXEC: begin
        if (w_rd_op)                  w_next = S_RD1_B;
        else if (w_op == OP_DSTORE)   w_next = S_WR_B;
        else if (w_halt)              w_next = S_HALT;
        else                          w_next = w_after;
      end
      S_RD1_B: w_next = S_RD1_C;
      S_RD1_C: begin
        if (w_op == OP_ILOAD)         w_next = S_RD2_A;
        else if (w_op == OP_ISTORE)   w_next = S_WR_A;
        else                          w_next = w_after;
      end
      S_RD2_A:  w_next = S_RD2_B;
      S_RD2_B:  w_next = S_RD2_C;
      S_RD2_C:  w_next = w_after;
      S_WR_A:   w_next = S_WR_B;
      S_WR_B:   w_next = w_after;
      S_PAUSED: w_next = pause ? S_PAUSED : S_FETCH_A;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc   <= '0;
      r_ireg <= '0;
      r_acc  <= '0;
      r_iar  <= '0;
    end else begin
      case (r_state)
        S_FETCH_C: begin
          r_ireg <= Data_Bus;
          r_pc   <= r_pc + 8'd1;
        end
        S_EXEC: begin
          case (w_op)
            OP_MISC:                     if (w_x == 4'h1) r_acc <= -r_acc;
            OP_BR, OP_BRZ, OP_BRP, OP_BRN: if (w_taken) r_pc <= r_pc + w_sext;
            OP_CLOAD:                    r_acc <= w_sext;
            default: ;
          endcase
        end
        S_RD1_C: begin
          case (w_op)
            OP_BRIND:            r_pc  <= Data_Bus;
            OP_DLOAD:            r_acc <= Data_Bus;
            OP_ILOAD, OP_ISTORE: r_iar <= Data_Bus;
            OP_ADD:              r_acc <= r_acc + Data_Bus;
            OP_AND:              r_acc <= r_acc & Data_Bus;
            default: ;
          endcase
        end
        S_RD2_C: r_acc <= Data_Bus;
        default: ;
      endcase
    end
  end

  // Bus strobes are forced idle while rst is low so reset is visible without a clock.
  always_comb begin
    ALE         = 1'b0;
    En          = 1'b0;
    Rw          = 1'b1;
    Address_Bus = r_pc;
    w_drive     = 1'b0;
    case (r_state)
      S_FETCH_A: ALE = 1'b1;
      S_FETCH_B, S_RD1_B, S_RD2_B: En = 1'b1;
      S_EXEC: begin
        if (w_rd_op) begin
          ALE         = 1'b1;
          Address_Bus = w_daddr;
        end else if (w_op == OP_DSTORE) begin
          ALE         = 1'b1;
          Rw          = 1'b0;
          Address_Bus = w_daddr;
        end
      end
      S_RD2_A: begin
        ALE         = 1'b1;
        Address_Bus = r_iar;
      end
      S_WR_A: begin
        ALE         = 1'b1;
        Rw          = 1'b0;
        Address_Bus = r_iar;
      end
      S_WR_B: begin
        En      = 1'b1;
        Rw      = 1'b0;
        w_drive = 1'b1;
      end
      default: ;
    endcase
    if (!rst) begin
      ALE     = 1'b0;
      En      = 1'b0;
      Rw      = 1'b1;
      w_drive = 1'b0;
    end
  end

  assign Data_Bus = w_drive ? r_acc : 'z;

  always_comb begin
    dispReg = r_pc;
    case (regSelect)
      2'b00:   dispReg = r_pc;
      2'b01:   dispReg = r_ireg;
      2'b10:   dispReg = r_acc;
      default: dispReg = r_iar;
    endcase
  end

endmodule

// File: tb/tb_very_half_sam_core.sv
// Bench for very_half_sam_core: bus-level memory model plus an instruction-level reference
// that predicts every bus transaction (cycle, address, direction) and the final architectural state.
module tb_very_half_sam_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] regSelect = 2'b00;
  logic       ALE, En, Rw;
  logic [7:0] Address_Bus;
  logic [7:0] dispReg;
  wire  [7:0] Data_Bus;

  very_half_sam_core dut (
    .clk(clk), .rst(rst), .ALE(ALE), .Address_Bus(Address_Bus), .Data_Bus(Data_Bus),
    .En(En), .Rw(Rw), .pause(pause), .regSelect(regSelect), .dispReg(dispReg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cyc;
    logic [7:0]  addr;
    logic        rw;
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: image reloaded from init_mem while reset is held
  logic [7:0] init_mem [256];
  logic [7:0] tb_mem   [256];
  logic [7:0] got_mem  [256];
  logic [7:0] m_addr;
  logic [7:0] mem_dout;
  logic       mem_drive;

  assign Data_Bus = mem_drive ? mem_dout : 'z;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_drive <= 1'b0;
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_mem[i];
    end else begin
      if (ALE) begin
        m_addr <= Address_Bus;
        if (!Rw) mem_drive <= 1'b0;
      end
      if (En && Rw) begin
        mem_drive <= 1'b1;
        mem_dout  <= tb_mem[m_addr];
      end
      if (En && !Rw) tb_mem[m_addr] <= Data_Bus;
    end
  end

  // Bus monitor
  int   cyc  = 0;
  int   base = 0;
  int   viol = 0;
  txn_t obs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    txn_t t;
    if (rst) begin
      if (ALE) begin
        t.cyc  = 16'(cyc - base);
        t.addr = Address_Bus;
        t.rw   = Rw;
        obs_q.push_back(t);
      end
      if (Rw && !mem_drive && (Data_Bus !== 8'hzz)) viol++;
    end
  end

  // Instruction-level reference
  txn_t       exp_q[$];
  logic [7:0] exp_mem [256];
  logic [7:0] exp_pc, exp_ir, exp_acc, exp_iar;

  function automatic txn_t mk(input int t, input logic [7:0] a, input logic rw);
    txn_t r;
    r.cyc  = 16'(t);
    r.addr = a;
    r.rw   = rw;
    return r;
  endfunction

  task automatic run_model(input int max_instr, output int t_end, output bit halted);
    logic [7:0] m [256];
    logic [7:0] pc, ir, acc, iar, sx, da;
    logic [3:0] op, x;
    int t;
    m = init_mem;
    pc = 8'h00; ir = 8'h00; acc = 8'h00; iar = 8'h00;
    t = 0;
    halted = 1'b0;
    exp_q.delete();
    for (int n = 0; n < max_instr && !halted; n++) begin
      exp_q.push_back(mk(t, pc, 1'b1));
      ir = m[pc];
      pc = pc + 8'd1;
      t += 3;
      op = ir[7:4];
      x  = ir[3:0];
      sx = {{4{x[3]}}, x};
      da = {4'h0, x};
      case (op)
        4'h0: begin
          t += 1;
          if (x == 4'h0) halted = 1'b1;
          else if (x == 4'h1) acc = 8'h00 - acc;
        end
        4'h1: begin t += 1; pc = pc + sx; end
        4'h2: begin t += 1; if (acc == 8'h00) pc = pc + sx; end
        4'h3: begin t += 1; if (acc > 8'h00 && acc < 8'h80) pc = pc + sx; end
        4'h4: begin t += 1; if (acc >= 8'h80) pc = pc + sx; end
        4'h5: begin exp_q.push_back(mk(t, da, 1'b1)); pc = m[da]; t += 3; end
        4'h6: begin t += 1; acc = sx; end
        4'h7: begin exp_q.push_back(mk(t, da, 1'b1)); acc = m[da]; t += 3; end
        4'h8: begin
          exp_q.push_back(mk(t, da, 1'b1));
          iar = m[da];
          exp_q.push_back(mk(t + 3, iar, 1'b1));
          acc = m[iar];
          t += 6;
        end
        4'h9: begin exp_q.push_back(mk(t, da, 1'b0)); m[da] = acc; t += 2; end
        4'hA: begin
          exp_q.push_back(mk(t, da, 1'b1));
          iar = m[da];
          exp_q.push_back(mk(t + 3, iar, 1'b0));
          m[iar] = acc;
          t += 5;
        end
        4'hB: begin exp_q.push_back(mk(t, da, 1'b1)); acc = acc + m[da]; t += 3; end
        4'hC: begin exp_q.push_back(mk(t, da, 1'b1)); acc = acc & m[da]; t += 3; end
        default: begin t += 1; halted = 1'b1; end
      endcase
    end
    t_end = t;
    exp_pc = pc; exp_ir = ir; exp_acc = acc; exp_iar = iar;
    exp_mem = m;
  endtask

  logic [7:0] got_pc, got_ir, got_acc, got_iar;

  task automatic read_regs();
    regSelect = 2'b00; #1 got_pc  = dispReg;
    regSelect = 2'b01; #1 got_ir  = dispReg;
    regSelect = 2'b10; #1 got_acc = dispReg;
    regSelect = 2'b11; #1 got_iar = dispReg;
  endtask

  task automatic reset_checks(input string name);
    check({name, " rst ALE"}, {31'h0, ALE}, 32'h0);
    check({name, " rst En"},  {31'h0, En},  32'h0);
    check({name, " rst Rw"},  {31'h0, Rw},  32'h1);
    check({name, " rst Data_Bus"}, {24'h0, Data_Bus}, {24'h0, 8'hzz});
    for (int s = 0; s < 4; s++) begin
      regSelect = 2'(s);
      #1 check($sformatf("%s rst dispReg sel%0d", name, s), {24'h0, dispReg}, 32'h0);
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    obs_q.delete();
    viol = 0;
    #1 rst = 1'b1;
    base = cyc;
  endtask

  task automatic run_prog(input string name, input int max_instr);
    int t_end;
    bit halted;
    int nbad, first;
    txn_t kept[$];
    run_model(max_instr, t_end, halted);
    release_reset();
    repeat (t_end) @(posedge clk);
    @(negedge clk);
    read_regs();
    check({name, " PC"},   {24'h0, got_pc},  {24'h0, exp_pc});
    check({name, " IREG"}, {24'h0, got_ir},  {24'h0, exp_ir});
    check({name, " ACC"},  {24'h0, got_acc}, {24'h0, exp_acc});
    check({name, " IAR"},  {24'h0, got_iar}, {24'h0, exp_iar});
    if (halted) repeat (8) @(negedge clk);
    foreach (obs_q[i]) if (halted || obs_q[i].cyc < 16'(t_end)) kept.push_back(obs_q[i]);
    check({name, " txn count"}, kept.size(), exp_q.size());
    for (int i = 0; i < kept.size() && i < exp_q.size(); i++)
      check($sformatf("%s txn%0d {cyc,addr,rw}", name, i), {7'h0, kept[i]}, {7'h0, exp_q[i]});
    nbad = 0;
    first = 0;
    for (int i = 255; i >= 0; i--) if (tb_mem[i] !== exp_mem[i]) begin nbad++; first = i; end
    check($sformatf("%s mem@%02h", name, first), {24'h0, tb_mem[first]}, {24'h0, exp_mem[first]});
    check({name, " mem mismatches"}, nbad, 0);
    check({name, " no drive while Rw=1"}, viol, 0);
    got_mem = tb_mem;
    #2 rst = 1'b0;
    #1 reset_checks(name);
  endtask

  task automatic clear_image();
    for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    clear_image();
    repeat (2) @(posedge clk);
    #1 reset_checks("por");
    release_reset();
    @(negedge clk);
    check("first ALE", {23'h0, ALE, Address_Bus}, {23'h0, 1'b1, 8'h00});
    #2 rst = 1'b0;

    // cload / dstore / halt
    clear_image();
    init_mem[0] = 8'h63; init_mem[1] = 8'h94; init_mem[2] = 8'h00;
    run_prog("cload_dstore", 64);
    check("cload_dstore M4",  {24'h0, got_mem[4]}, 32'h03);
    check("cload_dstore ACC", {24'h0, got_acc}, 32'h03);
    check("cload_dstore PC",  {24'h0, got_pc},  32'h03);

    // sext cload, negate, add, store
    clear_image();
    init_mem[0] = 8'h6D; init_mem[1] = 8'h01; init_mem[2] = 8'hB5;
    init_mem[3] = 8'h96; init_mem[4] = 8'h00; init_mem[5] = 8'h05;
    run_prog("arith", 64);
    check("arith ACC", {24'h0, got_acc}, 32'h08);
    check("arith M6",  {24'h0, got_mem[6]}, 32'h08);

    // branches, including chain through 0x10 -> 0x13
    clear_image();
    init_mem[8'h00] = 8'h17; init_mem[8'h08] = 8'h17; init_mem[8'h10] = 8'h12;
    run_prog("branch", 64);
    check("branch PC", {24'h0, got_pc}, 32'h14);

    // iload / istore
    clear_image();
    init_mem[0] = 8'h82; init_mem[1] = 8'hA3; init_mem[2] = 8'h0A; init_mem[3] = 8'h0B;
    init_mem[8'h0A] = 8'h5A;
    run_prog("indirect", 64);
    check("indirect ACC",  {24'h0, got_acc}, 32'h5A);
    check("indirect M0B",  {24'h0, got_mem[8'h0B]}, 32'h5A);
    check("indirect IAR",  {24'h0, got_iar}, 32'h0B);

    // pause raised during the first instruction
    clear_image();
    init_mem[0] = 8'h63; init_mem[1] = 8'h94; init_mem[2] = 8'h00;
    release_reset();
    repeat (2) @(negedge clk);
    pause = 1'b1;
    repeat (18) @(negedge clk);
    read_regs();
    check("pause PC frozen",  {24'h0, got_pc},  32'h01);
    check("pause ACC",        {24'h0, got_acc}, 32'h03);
    check("pause IREG",       {24'h0, got_ir},  32'h63);
    check("pause bus quiet",  obs_q.size(), 1);
    @(negedge clk);
    pause = 1'b0;
    repeat (20) @(negedge clk);
    check("pause txn count", obs_q.size(), 4);
    if (obs_q.size() >= 4) begin
      check("pause resume fetch", {7'h0, obs_q[1]}, {7'h0, 16'd21, 8'h01, 1'b1});
      check("pause dstore",       {7'h0, obs_q[2]}, {7'h0, 16'd24, 8'h04, 1'b0});
      check("pause last fetch",   {7'h0, obs_q[3]}, {7'h0, 16'd26, 8'h02, 1'b1});
    end
    check("pause M4", {24'h0, tb_mem[4]}, 32'h03);
    #2 rst = 1'b0;

    // random programs
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(0, 15) < 2) b = 8'($urandom);
        else b = {4'($urandom_range(1, 12)), 4'($urandom)};
        init_mem[i] = b;
      end
      run_prog($sformatf("rand%0d", p), 40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
